// File: rtl/axil_reg_slice.sv
// AXI4-Lite register slice. Each of the five channels gets its own bypass,
// forward-register or skid-buffer stage, selected per channel by a mode parameter.

module axil_reg_slice_chan #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MODE  = 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  if (MODE == 0) begin : g_bypass
    // Pure wires; clock and reset are intentionally unused here
    logic unused_clk_rst;
    assign unused_clk_rst = aclk ^ aresetn;
    assign out_data  = in_data;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
  end else if (MODE == 1) begin : g_fwd
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Payload is cleared whenever the stage empties
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (in_ready) begin
        valid_q <= in_valid;
        data_q  <= in_valid ? in_data : '0;
      end
    end
  end else begin : g_skid
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] out_q, out_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             valid_q, ready_q;
    logic             in_fire, out_fire;

    assign in_fire   = in_valid && ready_q;
    assign out_fire  = valid_q && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = out_q;

    // Ready and valid are decoded from the next state so both stay registered
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        state_q <= EMPTY;
        out_q   <= '0;
        skid_q  <= '0;
        valid_q <= 1'b0;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_n;
        out_q   <= out_n;
        skid_q  <= skid_n;
        valid_q <= (state_n != EMPTY);
        ready_q <= (state_n != FULL);
      end
    end

    always_comb begin
      state_n = state_q;
      out_n   = out_q;
      skid_n  = skid_q;
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            out_n   = in_data;
            state_n = ONE;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            skid_n  = in_data;
            state_n = FULL;
          end else if (!in_fire && out_fire) begin
            out_n   = '0;
            state_n = EMPTY;
          end else if (in_fire && out_fire) begin
            out_n = in_data;
          end
        end
        FULL: begin
          // Upstream is stalled here, so only a drain can occur
          if (out_fire) begin
            out_n   = skid_q;
            skid_n  = '0;
            state_n = ONE;
          end
        end
        default: begin
          state_n = EMPTY;
          out_n   = '0;
          skid_n  = '0;
        end
      endcase
    end
  end

endmodule

module axil_reg_slice #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned AW_MODE    = 2,
  parameter int unsigned W_MODE     = 2,
  parameter int unsigned B_MODE     = 2,
  parameter int unsigned AR_MODE    = 2,
  parameter int unsigned R_MODE     = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,

  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam int unsigned AX_W = ADDR_WIDTH + 3;
  localparam int unsigned W_W  = DATA_WIDTH + STRB_WIDTH;
  localparam int unsigned B_W  = 2;
  localparam int unsigned R_W  = DATA_WIDTH + 2;

  logic [AX_W-1:0] aw_out, ar_out;
  logic [W_W-1:0]  w_out;
  logic [B_W-1:0]  b_out;
  logic [R_W-1:0]  r_out;

  assign {m_axil_awprot, m_axil_awaddr} = aw_out;
  assign {m_axil_wstrb, m_axil_wdata}   = w_out;
  assign s_axil_bresp                   = b_out;
  assign {m_axil_arprot, m_axil_araddr} = ar_out;
  assign {s_axil_rresp, s_axil_rdata}   = r_out;

  axil_reg_slice_chan #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   ({s_axil_awprot, s_axil_awaddr}),
    .in_valid  (s_axil_awvalid),
    .in_ready  (s_axil_awready),
    .out_data  (aw_out),
    .out_valid (m_axil_awvalid),
    .out_ready (m_axil_awready)
  );

  axil_reg_slice_chan #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   ({s_axil_wstrb, s_axil_wdata}),
    .in_valid  (s_axil_wvalid),
    .in_ready  (s_axil_wready),
    .out_data  (w_out),
    .out_valid (m_axil_wvalid),
    .out_ready (m_axil_wready)
  );

  // Response channels flow from master side back to slave side
  axil_reg_slice_chan #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   (m_axil_bresp),
    .in_valid  (m_axil_bvalid),
    .in_ready  (m_axil_bready),
    .out_data  (b_out),
    .out_valid (s_axil_bvalid),
    .out_ready (s_axil_bready)
  );

  axil_reg_slice_chan #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   ({s_axil_arprot, s_axil_araddr}),
    .in_valid  (s_axil_arvalid),
    .in_ready  (s_axil_arready),
    .out_data  (ar_out),
    .out_valid (m_axil_arvalid),
    .out_ready (m_axil_arready)
  );

  axil_reg_slice_chan #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_data   ({m_axil_rresp, m_axil_rdata}),
    .in_valid  (m_axil_rvalid),
    .in_ready  (m_axil_rready),
    .out_data  (r_out),
    .out_valid (s_axil_rvalid),
    .out_ready (s_axil_rready)
  );

endmodule

// File: doc/axil_reg_slice.md
AXIL_REG_SLICE -- requirements
Module: axil_reg_slice

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values are 32 and 64.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 SHALL have parameters AW_MODE, W_MODE, B_MODE, AR_MODE and R_MODE, each default 2, per-channel mode: 0 = bypass, 1 = forward register, 2 = full skid buffer.
REQ-005 SHALL have port aclk, input, 1 bit, clock; all logic is on the rising edge.
REQ-006 SHALL have port aresetn, input, 1 bit, synchronous active-low reset.
REQ-007 SHALL have slave AW ports s_axil_awaddr/awprot/awvalid (in: ADDR_WIDTH, 3, 1) and s_axil_awready (out: 1).
REQ-008 SHALL have slave W ports s_axil_wdata/wstrb/wvalid (in: DATA_WIDTH, STRB_WIDTH, 1) and s_axil_wready (out: 1).
REQ-009 SHALL have slave B ports s_axil_bresp/bvalid (out: 2, 1) and s_axil_bready (in: 1).
REQ-010 SHALL have slave AR ports s_axil_araddr/arprot/arvalid (in: ADDR_WIDTH, 3, 1) and s_axil_arready (out: 1).
REQ-011 SHALL have slave R ports s_axil_rdata/rresp/rvalid (out: DATA_WIDTH, 2, 1) and s_axil_rready (in: 1).
REQ-012 SHALL have m_axil_* ports mirroring REQ-007..011, with directions inverted.

Function
REQ-013 SHALL implement each channel as an independent slice; AW, W and AR carry data slave-to-master, B and R carry data master-to-slave ("upstream" = sender side, "downstream" = receiver side).
REQ-014 SHALL, in mode 0, connect payload, valid and ready combinationally, with 0 latency and no state.
REQ-015 SHALL, in mode 1, hold downstream valid/payload in registers, updated only when downstream valid is 0 or downstream ready is 1.
REQ-016 SHALL, in mode 1, drive upstream ready = !downstream_valid || downstream_ready (combinational); latency is 1 cycle and throughput is 1 beat per cycle.
REQ-017 SHALL, in mode 2, register both upstream ready and downstream valid/payload, with one output register and one skid register per channel.
REQ-018 SHALL, in mode 2, accept an upstream beat into the output register when it is empty or draining that cycle; otherwise the beat goes to the skid register.
REQ-019 SHALL, in mode 2, use three states per slice: EMPTY (out=0, skid=0), ONE (out=1, skid=0) and FULL (out=1, skid=1).
REQ-020 SHALL make the mode 2 state transitions EMPTY->ONE on input; ONE->FULL on input without drain; ONE->EMPTY on drain without input; ONE->ONE on input with drain; FULL->ONE on drain, with the skid moving to the output.
REQ-021 SHALL, in mode 2, drive upstream ready = 1 exactly when the state is not FULL, from a register, with no combinational path from downstream ready.
REQ-022 SHALL, in mode 2, give 1-cycle latency and sustain 1 beat per cycle under continuous ready.
REQ-023 SHALL zero the payload register whenever its slice becomes empty (modes 1/2), so payload is 0 while valid is 0.
REQ-024 SHALL never drop, duplicate or reorder beats, and SHALL hold downstream payload stable while valid=1 and ready=0.
REQ-025 SHALL leave downstream valid unaffected by downstream ready within the same cycle (no valid-depends-on-ready path).
REQ-026 SHALL treat a transfer as occurring only when valid && ready, with no other qualifiers.

Reset
REQ-027 SHALL, while aresetn=0 at a rising edge, clear all valid, skid-valid and payload registers to 0 and set the mode 2 state to EMPTY.
REQ-028 SHALL hold mode 2 upstream ready at 0 during reset and drive it to 1 in the first cycle after release.
REQ-029 SHALL discard any in-flight beats when reset is asserted mid-transfer, with no output beat after release until new input arrives.

Verification
REQ-030 SHALL verify, in mode 2 with downstream ready held 1: AW beats addr 0x10, 0x14, 0x18 on consecutive cycles -> the same addresses appear 1 cycle later, back-to-back, and awready is never 0.
REQ-031 SHALL verify, in mode 2: downstream ready=0 for 3 cycles while W data 0xA5A5A5A5 then 0x5A5A5A5A is offered -> FULL, s_axil_wready=0, the first beat is held stable; on ready=1 both beats emerge in order on consecutive cycles.
REQ-032 SHALL verify, in mode 1: R beat rdata=0xDEADBEEF, rresp=2 with s_axil_rready=0 -> s_axil_rvalid held with the payload stable and m_axil_rready=0 until s_axil_rready=1.
REQ-033 SHALL verify, in mode 0: AR araddr=0x40 -> m_axil_araddr=0x40 in the same cycle, and arready follows m_axil_arready combinationally.
REQ-034 SHALL verify mode 2 reset in FULL: aresetn=0 for 1 cycle -> all valids=0, payload=0; after release, ready=1 and no stale beat is emitted.
REQ-035 SHALL verify, with all modes under random valid/ready throttling, 1000 beats per channel -> the scoreboard shows in-order, lossless delivery and no protocol-checker violations.
